alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_core.sv | 42 ++++
 rtl/alu_muldiv.sv | 173 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state encoding and defaults for alu_muldiv
package alu_pkg;

    localparam int ALU_OPW = 5;

    // Base ops
    localparam int unsigned ALU_ADD    = 0;
    localparam int unsigned ALU_SUB    = 1;
    localparam int unsigned ALU_SLL    = 2;
    localparam int unsigned ALU_SLT    = 3;
    localparam int unsigned ALU_SLTU   = 4;
    localparam int unsigned ALU_XOR    = 5;
    localparam int unsigned ALU_OR     = 6;
    localparam int unsigned ALU_AND    = 7;
    localparam int unsigned ALU_SRL    = 8;
    localparam int unsigned ALU_SRA    = 9;
    localparam int unsigned ALU_PASS1  = 11;
    localparam int unsigned ALU_PASS2  = 12;

    // M ops
    localparam int unsigned ALU_MUL    = 16;
    localparam int unsigned ALU_MULH   = 17;
    localparam int unsigned ALU_MULHSU = 18;
    localparam int unsigned ALU_MULHU  = 19;
    localparam int unsigned ALU_DIV    = 20;
    localparam int unsigned ALU_DIVU   = 21;
    localparam int unsigned ALU_REM    = 22;
    localparam int unsigned ALU_REMU   = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - single-cycle combinational base ALU operations
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = ALU_OPW
) (
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [OPW-1:0]  op,
    output logic [XLEN-1:0] out
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]    shamt;
    logic [31:0]       opi;

    assign shamt = in2[SHW-1:0];
    assign opi   = 32'(op);

    // Base operation select; M ops and undefined opcodes yield zero
    always_comb begin
        out = '0;
        case (opi)
            ALU_ADD:   out = in1 + in2;
            ALU_SUB:   out = in1 - in2;
            ALU_SLL:   out = in1 << shamt;
            ALU_SLT:   out = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            ALU_SLTU:  out = {{(XLEN-1){1'b0}}, (in1 < in2)};
            ALU_XOR:   out = in1 ^ in2;
            ALU_OR:    out = in1 | in2;
            ALU_AND:   out = in1 & in2;
            ALU_SRL:   out = in1 >> shamt;
            ALU_SRA:   out = $unsigned($signed(in1) >>> shamt);
            ALU_PASS1: out = in1;
            ALU_PASS2: out = in2;
            default:   out = '0;
        endcase
    end

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - ALU with iterative bit-serial multiply/divide and valid/ready handshake
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = ALU_OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [OPW-1:0]  op,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] MUL  = ST_MUL;
    localparam logic [1:0] DIV  = ST_DIV;
    localparam logic [1:0] DONE = ST_DONE;

    localparam logic [XLEN-1:0]   ONE  = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE2 = (2*XLEN)'(1);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] acc;      // mul: product high half; div: partial remainder
    logic [XLEN-1:0] qr;       // mul: multiplier / product low half; div: dividend / quotient
    logic [XLEN-1:0] mag_b;    // mul: multiplicand magnitude; div: divisor magnitude
    logic            neg_p;    // negate product or quotient at the end
    logic            neg_r;    // negate remainder at the end
    logic            sel_alt;  // select product high half or remainder
    logic [XLEN-1:0] out_r;

    logic [XLEN-1:0] core_out;
    logic [31:0]     opi;
    logic            is_mul, is_div, sgn1, sgn2;
    logic [XLEN-1:0] mag1, mag2;

    logic [XLEN+1:0] add_x, add_y, add_res;
    logic            add_sub;

    logic [XLEN-1:0]   m_hi, m_lo, d_r, d_q, quo_f, rem_f, mul_res, div_res;
    logic              d_neg, last;
    logic [2*XLEN-1:0] prod, prod_f;

    alu_core #(.XLEN(XLEN), .OPW(OPW)) u_core (
        .in1 (in1),
        .in2 (in2),
        .op  (op),
        .out (core_out)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = out_r;

    // Decode request: op class, operand signedness and magnitudes
    always_comb begin
        opi    = 32'(op);
        is_mul = (opi >= ALU_MUL) && (opi <= ALU_MULHU);
        is_div = (opi >= ALU_DIV) && (opi <= ALU_REMU);
        sgn1   = in1[XLEN-1] && (opi == ALU_MULH || opi == ALU_MULHSU ||
                                 opi == ALU_DIV  || opi == ALU_REM);
        sgn2   = in2[XLEN-1] && (opi == ALU_MULH || opi == ALU_DIV || opi == ALU_REM);
        mag1   = sgn1 ? (~in1 + ONE) : in1;
        mag2   = sgn2 ? (~in2 + ONE) : in2;
    end

    // Shared adder/subtractor: shift-add for multiply, trial subtract for divide
    always_comb begin
        add_x   = {2'b00, acc};
        add_y   = qr[0] ? {2'b00, mag_b} : '0;
        add_sub = 1'b0;
        if (state == DIV) begin
            add_x   = {1'b0, acc, qr[XLEN-1]};
            add_y   = {2'b00, mag_b};
            add_sub = 1'b1;
        end
        add_res = add_x + (add_y ^ {(XLEN+2){add_sub}}) + {{(XLEN+1){1'b0}}, add_sub};
    end

    // Next-iteration values and sign-corrected final results
    always_comb begin
        m_hi    = add_res[XLEN:1];
        m_lo    = {add_res[0], qr[XLEN-1:1]};
        d_neg   = add_res[XLEN+1];
        d_r     = d_neg ? {acc[XLEN-2:0], qr[XLEN-1]} : add_res[XLEN-1:0];
        d_q     = {qr[XLEN-2:0], ~d_neg};
        prod    = {m_hi, m_lo};
        prod_f  = neg_p ? (~prod + ONE2) : prod;
        mul_res = sel_alt ? prod_f[2*XLEN-1:XLEN] : prod_f[XLEN-1:0];
        quo_f   = neg_p ? (~d_q + ONE) : d_q;
        rem_f   = neg_r ? (~d_r + ONE) : d_r;
        div_res = sel_alt ? rem_f : quo_f;
        last    = (cnt == CW'(XLEN - 1));
    end

    // Control FSM and datapath registers; rst beats flush beats acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            qr      <= '0;
            mag_b   <= '0;
            neg_p   <= 1'b0;
            neg_r   <= 1'b0;
            sel_alt <= 1'b0;
            out_r   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt     <= '0;
                        acc     <= '0;
                        neg_p   <= (sgn1 ^ sgn2) && !(is_div && (in2 == '0));
                        neg_r   <= sgn1;
                        sel_alt <= (opi == ALU_MULH) || (opi == ALU_MULHSU) ||
                                   (opi == ALU_MULHU) || (opi == ALU_REM) ||
                                   (opi == ALU_REMU);
                        if (is_mul) begin
                            qr    <= mag2;
                            mag_b <= mag1;
                            state <= MUL;
                        end else if (is_div) begin
                            qr    <= mag1;
                            mag_b <= mag2;
                            state <= DIV;
                        end else begin
                            out_r <= core_out;
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    cnt <= cnt + CW'(1);
                    acc <= m_hi;
                    qr  <= m_lo;
                    if (last) begin
                        out_r <= mul_res;
                        state <= DONE;
                    end
                end
                DIV: begin
                    cnt <= cnt + CW'(1);
                    acc <= d_r;
                    qr  <= d_q;
                    if (last) begin
                        out_r <= div_res;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - table-driven self-checking bench for alu_muldiv
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1, in2;
    logic [4:0]  op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    alu_muldiv #(.XLEN(32), .OPW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a request and return after its acceptance edge; scramble inputs afterwards
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk("issue_ready", {63'd0, in_ready}, 64'd1);
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1 = $urandom;
        in2 = $urandom;
        op  = 5'($urandom);
    endtask

    // Count cycles from acceptance until out_valid (acceptance edge counts as 1)
    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic watch_no_result(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; op = '0;
        flush = 1'b0; out_ready = 1'b0;

        vecs.push_back(mk(5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000));
        vecs.push_back(mk(5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE));
        vecs.push_back(mk(5'd2,  32'h00000001, 32'h0000003F, 32'h80000000));
        vecs.push_back(mk(5'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001));
        vecs.push_back(mk(5'd4,  32'h00000001, 32'hFFFFFFFF, 32'h00000001));
        vecs.push_back(mk(5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0));
        vecs.push_back(mk(5'd6,  32'h12340000, 32'h00005678, 32'h12345678));
        vecs.push_back(mk(5'd7,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00));
        vecs.push_back(mk(5'd8,  32'h80000000, 32'h00000004, 32'h08000000));
        vecs.push_back(mk(5'd9,  32'h80000000, 32'h00000004, 32'hF8000000));
        vecs.push_back(mk(5'd10, 32'h00000123, 32'h00000456, 32'h00000000));
        vecs.push_back(mk(5'd11, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF));
        vecs.push_back(mk(5'd12, 32'hDEADBEEF, 32'hCAFEF00D, 32'hCAFEF00D));
        vecs.push_back(mk(5'd31, 32'h00000003, 32'h00000004, 32'h00000000));
        vecs.push_back(mk(5'd17, 32'h80000000, 32'h80000000, 32'h40000000));
        vecs.push_back(mk(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE));
        vecs.push_back(mk(5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001));
        vecs.push_back(mk(5'd16, 32'h00003039, 32'h00001A85, 32'h04FED79D));
        vecs.push_back(mk(5'd18, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF));
        vecs.push_back(mk(5'd17, 32'hFFFFFFFE, 32'h80000000, 32'h00000001));
        vecs.push_back(mk(5'd20, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD));
        vecs.push_back(mk(5'd22, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF));
        vecs.push_back(mk(5'd21, 32'h0000000A, 32'h00000000, 32'hFFFFFFFF));
        vecs.push_back(mk(5'd23, 32'h0000000A, 32'h00000000, 32'h0000000A));
        vecs.push_back(mk(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000));
        vecs.push_back(mk(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000));
        vecs.push_back(mk(5'd20, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF));
        vecs.push_back(mk(5'd22, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9));
        vecs.push_back(mk(5'd21, 32'h00000064, 32'h00000007, 32'h0000000E));
        vecs.push_back(mk(5'd23, 32'h00000064, 32'h00000007, 32'h00000002));
        vecs.push_back(mk(5'd21, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF));
        vecs.push_back(mk(5'd20, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD));
        vecs.push_back(mk(5'd22, 32'h00000007, 32'hFFFFFFFE, 32'h00000001));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out", {32'd0, out}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Table-driven vectors: result, latency, busy-while-done, ready after consume
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_result(lat);
            chk($sformatf("vec%0d_op%0d_out", i, vecs[i].op), {32'd0, out}, {32'd0, vecs[i].exp});
            chk($sformatf("vec%0d_lat", i), 64'(lat), (vecs[i].op >= 5'd16 && vecs[i].op <= 5'd23) ? 64'd33 : 64'd1);
            chk($sformatf("vec%0d_busy", i), {63'd0, in_ready}, 64'd0);
            consume();
            chk($sformatf("vec%0d_ready_after", i), {63'd0, in_ready}, 64'd1);
        end

        // Back-pressure: result held stable with in_ready low
        issue(5'd16, 32'd7, 32'd6);
        wait_result(lat);
        held = out;
        chk("hold_first", {32'd0, held}, 64'd42);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_out", k), {32'd0, out}, {32'd0, held});
            chk($sformatf("hold%0d_valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("hold%0d_ready", k), {63'd0, in_ready}, 64'd0);
        end
        consume();
        chk("hold_release_ready", {63'd0, in_ready}, 64'd1);

        // Flush wins over acceptance in the same cycle
        op = 5'd0; in1 = 32'd1; in2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_prio_ready", {63'd0, in_ready}, 64'd1);

        // Flush mid-divide at iteration 10
        issue(5'd21, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        chk("flush_busy", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        watch_no_result("flush_no_result");
        issue(5'd0, 32'd2, 32'd3);
        wait_result(lat);
        chk("post_flush_add", {32'd0, out}, 64'd5);
        chk("post_flush_lat", 64'(lat), 64'd1);
        consume();

        // Reset mid-multiply at iteration 20
        issue(5'd16, 32'h00010001, 32'h00000003);
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_out", {32'd0, out}, 64'd0);
        chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
        watch_no_result("rst_no_result");
        chk("rst_out_stays", {32'd0, out}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
